instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch unit. It owns the PC, issues word requests to instruction memory over a req/ack handshake, and presents one instruction at a time to the main control decoder and datapath.
- Its `opcode` output is `instr[31:26]`.
- When the held instruction is consumed, it takes the branch/jump controls the decoder produces for that instruction, plus the ALU zero flag, and resolves the next PC.
- No prefetch: at most one memory request is outstanding and at most one instruction is held.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  fetch enable; low blocks new requests.
- imem_req  out  1  memory request, registered.
- imem_addr  out  32  byte address of request, registered, stable while imem_req=1.
- imem_ack  in  1  memory accepts request; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  held instruction; opcode = instr[31:26].
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  datapath consumes instr this cycle.
- pc  out  32  address of held instr.
- pc_plus4  out  32  pc + 4.
- beq, bne, j  in  1 each  decoder controls for the held instr.
- zero  in  1  ALU zero flag for the held instr.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, imem_req=0, imem_addr=RESET_PC, instr=0, instr_valid=0, pc=RESET_PC, pc_plus4=RESET_PC+4.
  - Reset asserted mid-request abandons the request immediately; any late imem_ack is ignored.
- States: IDLE, FETCH, HOLD. All outputs are registered.
- IDLE:
  - imem_req=0.
  - en=1 → FETCH next cycle, with imem_req=1 and imem_addr = current PC.
- FETCH:
  - imem_req=1, imem_addr held stable.
  - imem_ack=1 → instr<=imem_rdata, pc<=imem_addr, pc_plus4<=imem_addr+4, instr_valid<=1, imem_req<=0, state<=HOLD.
  - A request in flight is always completed even if en drops.
  - Minimum latency from request to valid is 1 cycle (ack in the first req cycle).
- HOLD:
  - instr_valid=1; instr, pc and pc_plus4 are stable until consumed.
  - Consume = instr_valid & instr_ready. beq/bne/j/zero are sampled only on the consume cycle and ignored otherwise.
  - taken_br = (beq & zero) | (bne & ~zero).
  - next_pc priority: j → {pc_plus4[31:28], instr[25:0], 2'b00}; else taken_br → pc_plus4 + (sext(instr[15:0]) << 2); else pc_plus4.
  - All PC arithmetic is modulo 2^32 and wraps silently (e.g. 32'hFFFF_FFFC + 4 = 0).
  - On consume: instr_valid<=0, imem_addr<=next_pc. If en=1: imem_req<=1, state<=FETCH. If en=0: imem_req<=0, state<=IDLE.
- imem_ack while imem_req=0 is ignored.
- imem_rdata is captured only on the ack cycle.
- Throughput: at most one instruction every 2 cycles.
- If j and beq/bne are asserted together (illegal decode), j wins.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds two output ports, fetch_cnt[31:0] and redirect_cnt[31:0], both reset to 0.
  - fetch_cnt increments on each imem_ack accepted in FETCH.
  - redirect_cnt increments on each consume where next_pc != pc_plus4.
  - Both wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, en=1, memory acks every request in 1 cycle, instr_ready=1, no branches → imem_addr sequence 0,4,8,C; instr_valid pulses every 2nd cycle; pc matches each address.
- Held instr 32'h1000_0003 at pc=0x40, beq=1, zero=1 on consume → next imem_addr=0x50. Same with zero=0 → next imem_addr=0x44.
- Held instr 32'h1400_FFFE at pc=0x100, bne=1, zero=0 → next imem_addr=0x0FC.
- Held instr 32'h0800_0010 at pc=0x8000_0000, j=1 → next imem_addr=0x8000_0040.
- Backpressure and slow memory:
  - instr_ready=0 for 5 cycles → instr, pc and instr_valid stable, imem_req=0.
  - imem_ack delayed 3 cycles → imem_addr held stable, imem_req=1 throughout.
- en dropped during FETCH → request completes, instr delivered; after consume state is IDLE with imem_req=0. rst_n pulsed low mid-FETCH → instant return to reset values, imem_addr=RESET_PC. With FETCH_PERF_CNT_EN, scenario 1 plus one taken branch gives counts matching the number of acks and redirects.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over req/ack, resolves next PC.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt and redirect_cnt performance counters.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        beq,
  input  logic        bne,
  input  logic        j,
  input  logic        zero
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] redirect_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;

  logic        consume;
  logic        fetch_done;
  logic        taken_br;
  logic [31:0] jump_target;
  logic [31:0] br_target;
  logic [31:0] next_pc;

  // Decoder controls only matter on the consume cycle; all arithmetic wraps mod 2^32.
  assign consume     = valid_q & instr_ready;
  assign taken_br    = (beq & zero) | (bne & ~zero);
  assign jump_target = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
  assign br_target   = pc_plus4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4_q;
    if (j) begin
      next_pc = jump_target;
    end else if (taken_br) begin
      next_pc = br_target;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    fetch_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          req_d   = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // An outstanding request always completes, regardless of en.
        if (imem_ack) begin
          instr_d    = imem_rdata;
          pc_d       = addr_q;
          pc_plus4_d = addr_q + 32'd4;
          valid_d    = 1'b1;
          req_d      = 1'b0;
          fetch_done = 1'b1;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (consume) begin
          valid_d = 1'b0;
          addr_d  = next_pc;
          req_d   = en;
          state_d = en ? StFetch : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      instr_q    <= 32'h0;
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + 32'd4;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] redirect_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q    <= 32'h0;
      redirect_cnt_q <= 32'h0;
    end else begin
      if (fetch_done) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (consume && (state_q == StHold) && (next_pc != pc_plus4_q)) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, branches, jumps, backpressure, slow memory,
// en drop and mid-fetch reset; a second instance built with a high RESET_PC checks jump targets.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        beq = 1'b0;
  logic        bne = 1'b0;
  logic        j = 1'b0;
  logic        zero = 1'b0;

  logic        en_hi = 1'b0;
  logic        hi_req;
  logic [31:0] hi_addr;
  logic        hi_ack = 1'b0;
  logic [31:0] hi_instr;
  logic        hi_valid;
  logic [31:0] hi_pc;
  logic [31:0] hi_pc_plus4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;
  logic [31:0] hi_fetch_cnt;
  logic [31:0] hi_redirect_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  instr_fetch u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .beq         (beq),
    .bne         (bne),
    .j           (j),
    .zero        (zero)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .redirect_cnt(redirect_cnt)
`endif
  );

  instr_fetch #(.RESET_PC(32'h8000_0000)) u_dut_hi (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en_hi),
    .imem_req    (hi_req),
    .imem_addr   (hi_addr),
    .imem_ack    (hi_ack),
    .imem_rdata  (32'h0800_0010),
    .instr       (hi_instr),
    .instr_valid (hi_valid),
    .instr_ready (1'b1),
    .pc          (hi_pc),
    .pc_plus4    (hi_pc_plus4),
    .beq         (1'b0),
    .bne         (1'b0),
    .j           (1'b1),
    .zero        (1'b0)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (hi_fetch_cnt),
    .redirect_cnt(hi_redirect_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hA000_0000 ^ a;
  endfunction

  // Memory model: acks after ack_delay idle request cycles, changes only on the falling edge.
  always @(negedge clk) begin
    if (imem_req) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        wait_cnt   = wait_cnt + 1;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      wait_cnt   = 0;
    end
    hi_ack = hi_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle consume with the given decoder controls, then release them.
  task automatic consume(input logic b_eq, input logic b_ne, input logic jmp, input logic z);
    beq = b_eq; bne = b_ne; j = jmp; zero = z; instr_ready = 1'b1;
    step();
    beq = 1'b0; bne = 1'b0; j = 1'b0; zero = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic await_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    check(tag, {31'h0, instr_valid}, 32'h1);
  endtask

  initial begin
    mem[32'h0000_000C] = 32'h0800_0010;  // j -> 0x40
    mem[32'h0000_0040] = 32'h1000_0003;  // beq +3
    mem[32'h0000_0050] = 32'h0800_0010;  // j -> 0x40
    mem[32'h0000_0044] = 32'h0800_0040;  // j -> 0x100
    mem[32'h0000_0100] = 32'h1400_FFFE;  // bne -2

    #1 rst_n = 1'b0;
    #1;
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_hi_addr", hi_addr, 32'h8000_0000);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; en = 1'b1; instr_ready = 1'b1;

    // Sequential fetch with single-cycle memory.
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("seq%0d_req", k), {31'h0, imem_req}, 32'h1);
      check($sformatf("seq%0d_addr", k), imem_addr, 32'(4 * k));
      check($sformatf("seq%0d_vld0", k), {31'h0, instr_valid}, 32'h0);
      step();
      check($sformatf("seq%0d_vld1", k), {31'h0, instr_valid}, 32'h1);
      check($sformatf("seq%0d_pc", k), pc, 32'(4 * k));
      check($sformatf("seq%0d_pc4", k), pc_plus4, 32'(4 * k + 4));
      check($sformatf("seq%0d_instr", k), instr, mem_word(32'(4 * k)));
      if (k == 3) instr_ready = 1'b0;
    end

    // Backpressure: controls wiggle but nothing is consumed.
    beq = 1'b1; zero = 1'b1; j = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("bp%0d_vld", k), {31'h0, instr_valid}, 32'h1);
      check($sformatf("bp%0d_pc", k), pc, 32'hC);
      check($sformatf("bp%0d_req", k), {31'h0, imem_req}, 32'h0);
      check($sformatf("bp%0d_instr", k), instr, 32'h0800_0010);
    end
    beq = 1'b0; zero = 1'b0; j = 1'b0;

    consume(1'b0, 1'b0, 1'b1, 1'b0);
    check("j_0x40_addr", imem_addr, 32'h40);
    check("j_0x40_req", {31'h0, imem_req}, 32'h1);
    step();
    check("at40_pc", pc, 32'h40);
    check("at40_instr", instr, 32'h1000_0003);
    consume(1'b1, 1'b0, 1'b0, 1'b1);
    check("beq_taken", imem_addr, 32'h50);
    step();
    check("at50_pc", pc, 32'h50);
    consume(1'b0, 1'b0, 1'b1, 1'b0);
    check("j_back_40", imem_addr, 32'h40);
    step();
    consume(1'b1, 1'b0, 1'b0, 1'b0);
    check("beq_not_taken", imem_addr, 32'h44);
    step();
    check("at44_instr", instr, 32'h0800_0040);
    consume(1'b0, 1'b0, 1'b1, 1'b0);
    check("j_0x100", imem_addr, 32'h100);
    step();
    check("at100_pc", pc, 32'h100);
    consume(1'b0, 1'b1, 1'b0, 1'b0);
    check("bne_taken", imem_addr, 32'hFC);

    // Slow memory: ack arrives on the fourth request cycle.
    ack_delay = 3;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("slow%0d_req", k), {31'h0, imem_req}, 32'h1);
      check($sformatf("slow%0d_addr", k), imem_addr, 32'hFC);
      check($sformatf("slow%0d_vld", k), {31'h0, instr_valid}, 32'h0);
    end
    step();
    check("slow_vld", {31'h0, instr_valid}, 32'h1);
    check("slow_pc", pc, 32'hFC);

    // en dropped while a request is in flight.
    ack_delay = 2;
    consume(1'b0, 1'b0, 1'b0, 1'b0);
    check("endrop_addr", imem_addr, 32'h100);
    en = 1'b0;
    await_valid("endrop_vld");
    check("endrop_instr", instr, 32'h1400_FFFE);
    check("endrop_pc", pc, 32'h100);
    consume(1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_req", {31'h0, imem_req}, 32'h0);
    check("idle_vld", {31'h0, instr_valid}, 32'h0);
    check("idle_addr", imem_addr, 32'h104);
    step();
    check("idle_req2", {31'h0, imem_req}, 32'h0);

    // Reset mid-fetch.
    ack_delay = 5;
    en = 1'b1;
    step();
    check("rf_req", {31'h0, imem_req}, 32'h1);
    check("rf_addr", imem_addr, 32'h104);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rf_rst_req", {31'h0, imem_req}, 32'h0);
    check("rf_rst_addr", imem_addr, 32'h0);
    check("rf_rst_vld", {31'h0, instr_valid}, 32'h0);
    check("rf_rst_pc", pc, 32'h0);
    check("rf_rst_pc4", pc_plus4, 32'h4);
    check("rf_rst_instr", instr, 32'h0);
    en = 1'b0;
    ack_delay = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("post_rst_req", {31'h0, imem_req}, 32'h0);

    // Jump from the high reset PC keeps pc_plus4[31:28].
    en_hi = 1'b1;
    step();
    check("hi_req", {31'h0, hi_req}, 32'h1);
    check("hi_addr0", hi_addr, 32'h8000_0000);
    en_hi = 1'b0;
    step();
    check("hi_vld", {31'h0, hi_valid}, 32'h1);
    check("hi_pc", hi_pc, 32'h8000_0000);
    step();
    check("hi_j_addr", hi_addr, 32'h8000_0040);
    check("hi_idle_req", {31'h0, hi_req}, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    en = 1'b1;
    instr_ready = 1'b1;
    repeat (8) step();
    check("perf_pc", pc, 32'hC);
    check("perf_fetch4", fetch_cnt, 32'd4);
    check("perf_redir0", redirect_cnt, 32'd0);
    beq = 1'b1; zero = 1'b1;
    step();
    beq = 1'b0; zero = 1'b0;
    check("perf_br_addr", imem_addr, 32'h50);
    check("perf_redir1", redirect_cnt, 32'd1);
    step();
    check("perf_fetch5", fetch_cnt, 32'd5);
    check("perf_hi_fetch", hi_fetch_cnt, 32'd1);
    check("perf_hi_redir", hi_redirect_cnt, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
